seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, registered ALU for the simple CPU datapath. It is the successor to the 8-bit combinational add/multiply unit and widens the operation set to eight opcodes. It accepts one operation per start/done handshake. Add, sub and logic ops complete in one clock; multiply runs as a WIDTH-cycle shift-add sequence. Results and flags are held in output registers until the next accepted operation.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk; accepted only while busy=0
- op  input  3  opcode, sampled with start
- input_1  input  WIDTH  operand A, sampled with start
- input_2  input  WIDTH  operand B, sampled with start
- output_1  output  WIDTH  registered result
- carry  output  1  registered carry/borrow/overflow flag
- zero  output  1  registered, 1 when the loaded result is 0
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse, high in the cycle after a result is loaded

## Operation
- Opcodes:
  - 000 ADD: A+B; carry = carry-out of bit WIDTH-1
  - 001 SUB: A-B (mod 2^WIDTH); carry = borrow (1 when A<B, unsigned)
  - 010 AND: A&B; carry=0
  - 011 OR: A|B; carry=0
  - 100 XOR: A^B; carry=0
  - 101 NOT: ~A; B ignored; carry=0
  - 110 MUL: low WIDTH bits of the unsigned A*B; carry = 1 when the upper WIDTH bits of the full 2*WIDTH product are nonzero
  - 111 PASS: A; carry=0
- zero = (result == 0); it is computed on every load, including MUL.
- FSM states:
  - IDLE
    - start=1 with op≠MUL: load output_1/carry/zero; stay in IDLE.
    - start=1 with op=MUL: latch A, clear the 2*WIDTH accumulator, clear the bit counter, go to MUL.
  - MUL
    - Each clock: if the current multiplier bit is 1, add the shifted multiplicand into the accumulator; then increment the counter.
    - After WIDTH iterations: load output_1/carry/zero from the accumulator and return to IDLE.
- busy = (state==MUL).
- start while busy=1 is ignored: no queueing, and operands are not re-sampled.
- output_1, carry and zero change only on a result load. They hold their value between operations, and during a multiply.
- Internal arithmetic uses WIDTH+1 bits for ADD/SUB and 2*WIDTH bits for the MUL accumulator. Nothing is truncated before flag extraction.

## Timing
- Reset (async assert, output effect immediate): output_1=0, carry=0, zero=0, busy=0, done=0, state=IDLE, counter=0.
- Deassertion of rst_n is synchronised externally. The first usable edge is the first rising clk with rst_n=1.
- Single-cycle ops:
  - start is sampled at edge E0.
  - Result and flags are visible after E0; done=1 for exactly the cycle E0..E1.
  - Back-to-back starts on consecutive edges are legal. Each produces its own done pulse, so done can stay high continuously.
- MUL:
  - Accepted at E0; busy=1 after E0.
  - Result loaded at edge E(WIDTH); busy=0 and done=1 after E(WIDTH); done drops after E(WIDTH+1).
  - Total latency is WIDTH clocks from the accepting edge to done.
  - A new start is accepted at E(WIDTH+1) at the earliest, because start at E(WIDTH) is still seen with busy=1.
- Reset asserted mid-MUL aborts the operation: no done pulse, and outputs return to their reset values.
- Operands and op may change freely after the accepting edge without effect.

## Test plan
- Reset state: hold rst_n=0, then release -> output_1=0, carry=0, zero=0, busy=0, done=0.
- ADD 200+100, then SUB 5-7 (WIDTH=8) -> output_1=44 with carry=1, then 254 with carry=1. Each done pulse is exactly 1 cycle; back-to-back starts give two consecutive done cycles.
- MUL 13*11 -> busy high for 8 cycles, done on the 8th edge after acceptance, output_1=143, carry=0, zero=0. output_1 holds its prior value while busy.
- MUL 16*16 -> output_1=0, carry=1, zero=1; MUL 255*255 -> output_1=1, carry=1.
- start with op=ADD pulsed during an active MUL -> ignored; the MUL result is unaffected and only one done pulse occurs.
- rst_n pulsed low at cycle 4 of a MUL -> no done pulse; outputs are reset; a subsequent AND 0xF0&0x3C gives 0x30.

Source files
------------

// File: rtl/seq_alu_if.sv
// -----------------------------------------------------------------------------
// seq_alu_if
// Handshake and data bundle for the sequential ALU.
//   start     request strobe, sampled on rising clk while busy=0
//   op        3-bit opcode, sampled with start
//   input_1   operand A, sampled with start
//   input_2   operand B, sampled with start
//   output_1  registered result
//   carry     registered carry / borrow / multiply-overflow flag
//   zero      registered, high when the loaded result is 0
//   busy      high while a multiply is in progress
//   done      one-cycle pulse in the cycle after a result load
// Modports: master (requester side), slave (ALU side).
// -----------------------------------------------------------------------------
interface seq_alu_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] input_1;
   logic [WIDTH-1:0] input_2;
   logic [WIDTH-1:0] output_1;
   logic             carry;
   logic             zero;
   logic             busy;
   logic             done;

   modport master (
      output start, op, input_1, input_2,
      input  output_1, carry, zero, busy, done
   );

   modport slave (
      input  start, op, input_1, input_2,
      output output_1, carry, zero, busy, done
   );
endinterface

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Registered ALU with a start/done handshake. ADD, SUB and the logic ops
// complete in one clock; MUL is a WIDTH-cycle shift-add sequence. Result and
// flags are held in output registers until the next accepted operation.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_alu_if slave modport (start/op/operands in, result/flags out)
// Parameter:
//   WIDTH  operand/result width, 2..32
// -----------------------------------------------------------------------------
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   seq_alu_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_NOT  = 3'b101,
      OP_MUL  = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_e;

   op_e                op_in;
   state_e             state;
   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   result_q;
   logic               carry_q;
   logic               zero_q;
   logic               done_q;

   // Multiply datapath: multiplicand shifts left one place per iteration so
   // the current partial product is always aligned with the accumulator.
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic               mul_last;

   // Single-cycle datapath
   logic [WIDTH:0]     ext_sum;
   logic [WIDTH:0]     ext_diff;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry;

   logic               accept;

   assign op_in    = op_e'(bus.op);
   assign accept   = (state == S_IDLE) && bus.start;
   assign mul_last = (count == CW'(WIDTH - 1));

   // One extra bit keeps the carry-out / borrow of bit WIDTH-1.
   assign ext_sum  = {1'b0, bus.input_1} + {1'b0, bus.input_2};
   assign ext_diff = {1'b0, bus.input_1} - {1'b0, bus.input_2};

   // NOTE: every signal assigned in an always_comb gets a default before the
   // case, so no path can leave it unassigned and infer a latch.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      case (op_in)
         OP_ADD: begin
            alu_res   = ext_sum[WIDTH-1:0];
            alu_carry = ext_sum[WIDTH];
         end
         OP_SUB: begin
            // Top bit of the wrapped difference is set exactly when A < B.
            alu_res   = ext_diff[WIDTH-1:0];
            alu_carry = ext_diff[WIDTH];
         end
         OP_AND:  alu_res = bus.input_1 & bus.input_2;
         OP_OR:   alu_res = bus.input_1 | bus.input_2;
         OP_XOR:  alu_res = bus.input_1 ^ bus.input_2;
         OP_NOT:  alu_res = ~bus.input_1;
         OP_PASS: alu_res = bus.input_1;
         default: begin
            alu_res   = '0;
            alu_carry = 1'b0;
         end
      endcase
   end

   // Full 2*WIDTH accumulation; after the last iteration this is the exact
   // product, so the overflow flag comes from its untruncated upper half.
   assign acc_next = acc + (mplier[count] ? mcand : '0);

   // NOTE: operand and accumulator registers have no reset. They are always
   // loaded on the accepting edge before anything reads them, and a reset
   // returns the FSM to IDLE where their contents are ignored.
   always_ff @(posedge clk) begin
      if (accept && (op_in == OP_MUL)) begin
         mcand  <= {{WIDTH{1'b0}}, bus.input_1};
         mplier <= bus.input_2;
         acc    <= '0;
      end else if (state == S_MUL) begin
         mcand  <= mcand << 1;
         acc    <= acc_next;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         count    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  if (op_in == OP_MUL) begin
                     count <= '0;
                     state <= S_MUL;
                  end else begin
                     result_q <= alu_res;
                     carry_q  <= alu_carry;
                     zero_q   <= (alu_res == '0);
                     done_q   <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               // start is ignored here: no queueing, no operand re-sampling.
               if (mul_last) begin
                  result_q <= acc_next[WIDTH-1:0];
                  carry_q  <= |acc_next[2*WIDTH-1:WIDTH];
                  zero_q   <= (acc_next[WIDTH-1:0] == '0);
                  done_q   <= 1'b1;
                  count    <= '0;
                  state    <= S_IDLE;
               end else begin
                  count <= count + CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.output_1 = result_q;
   assign bus.carry    = carry_q;
   assign bus.zero     = zero_q;
   assign bus.done     = done_q;
   assign bus.busy     = (state == S_MUL);

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Bench for seq_alu (WIDTH=8). A reference model computes each result with
// plain integer arithmetic and a cycle countdown for MUL; a compare process
// checks every output on every falling edge. Directed sequences pin literal
// values; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_seq_alu;
   localparam int WIDTH = 8;
   localparam longint unsigned MASK = (64'd1 << WIDTH) - 64'd1;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_OP = 3'd2, MUL = 3'd6;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   bit   chk_en = 1'b0;

   seq_alu_if #(.WIDTH(WIDTH)) bus ();

   seq_alu #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int unsigned     m_left;   // remaining MUL clocks, 0 when idle
   longint unsigned m_prod;
   longint unsigned e_out;
   bit              e_carry, e_zero, e_done;

   task automatic set_result(input longint unsigned v, input bit c);
      e_out   = v & MASK;
      e_carry = c;
      e_zero  = ((v & MASK) == 0);
      e_done  = 1'b1;
   endtask

   always @(posedge clk or negedge rst_n) begin
      longint unsigned a, b, s;
      if (!rst_n) begin
         m_left = 0; e_out = 0; e_carry = 0; e_zero = 0; e_done = 0;
      end else begin
         e_done = 1'b0;
         if (m_left != 0) begin
            m_left--;
            if (m_left == 0) set_result(m_prod, (m_prod >> WIDTH) != 0);
         end else if (bus.start === 1'b1) begin
            a = longint'(bus.input_1);
            b = longint'(bus.input_2);
            case (bus.op)
               3'd0: begin s = a + b; set_result(s, s > MASK); end
               3'd1: set_result(a - b, a < b);
               3'd2: set_result(a & b, 1'b0);
               3'd3: set_result(a | b, 1'b0);
               3'd4: set_result(a ^ b, 1'b0);
               3'd5: set_result(~a, 1'b0);
               3'd6: begin m_prod = a * b; m_left = WIDTH; end
               default: set_result(a, 1'b0);
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("output_1", bus.output_1, e_out);
         check("carry", bus.carry, e_carry);
         check("zero", bus.zero, e_zero);
         check("busy", bus.busy, m_left != 0);
         check("done", bus.done, e_done);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic scramble();
      bus.op      = 3'($urandom);
      bus.input_1 = WIDTH'($urandom);
      bus.input_2 = WIDTH'($urandom);
   endtask

   // Presents one request for exactly one edge; returns just after that edge.
   task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = op; bus.input_1 = a; bus.input_2 = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      scramble();
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.done !== 1'b1 && n < budget);
      check("done_within_budget", bus.done, 1'b1);
   endtask

   function automatic logic [WIDTH-1:0] pick_operand();
      case ($urandom % 4)
         0:       return '0;
         1:       return '1;
         default: return WIDTH'($urandom);
      endcase
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      int n;
      int ndone;

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.input_1 = '0;
      bus.input_2 = '0;
      #1 chk_en = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_output_1", bus.output_1, 0);
      check("rst_carry", bus.carry, 0);
      check("rst_zero", bus.zero, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      rst_n = 1'b1;

      // Back-to-back ADD 200+100 then SUB 5-7
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = ADD; bus.input_1 = 200; bus.input_2 = 100;
      @(posedge clk); #1;
      bus.op = SUB; bus.input_1 = 5; bus.input_2 = 7;
      @(negedge clk);
      check("add_result", bus.output_1, 44);
      check("add_carry", bus.carry, 1);
      check("add_done", bus.done, 1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("sub_result", bus.output_1, 254);
      check("sub_borrow", bus.carry, 1);
      check("sub_done", bus.done, 1);
      @(negedge clk);
      check("sub_done_drops", bus.done, 0);

      // MUL 13*11: busy for WIDTH cycles, prior result held meanwhile
      issue(MUL, 13, 11);
      for (int k = 0; k < WIDTH; k++) begin
         @(negedge clk);
         check("mul_busy", bus.busy, 1);
         check("mul_hold", bus.output_1, 254);
         check("mul_no_early_done", bus.done, 0);
      end
      @(negedge clk);
      check("mul13x11_done", bus.done, 1);
      check("mul13x11_result", bus.output_1, 143);
      check("mul13x11_carry", bus.carry, 0);
      check("mul13x11_zero", bus.zero, 0);
      check("mul13x11_busy_clear", bus.busy, 0);
      @(negedge clk);
      check("mul13x11_done_drops", bus.done, 0);

      // MUL 16*16 and 255*255
      issue(MUL, 16, 16);
      wait_done(WIDTH + 4, n);
      // First sample is after the accepting edge, so done arrives on sample WIDTH+1.
      check("mul_latency", n, WIDTH + 1);
      check("mul16x16_result", bus.output_1, 0);
      check("mul16x16_carry", bus.carry, 1);
      check("mul16x16_zero", bus.zero, 1);
      issue(MUL, 255, 255);
      wait_done(WIDTH + 4, n);
      check("mul255x255_result", bus.output_1, 1);
      check("mul255x255_carry", bus.carry, 1);
      check("mul255x255_zero", bus.zero, 0);

      // ADD starts while MUL 3*5 runs, including at the final MUL edge
      issue(MUL, 3, 5);
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (k == 1 || k == WIDTH - 2) begin
            bus.start = 1'b1; bus.op = ADD; bus.input_1 = 1; bus.input_2 = 1;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      check("ignored_start_one_done", ndone, 1);
      check("ignored_start_result", bus.output_1, 15);

      // Reset during cycle 4 of a MUL aborts it
      issue(MUL, 200, 3);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("abort_output_1", bus.output_1, 0);
      check("abort_carry", bus.carry, 0);
      check("abort_busy", bus.busy, 0);
      #2 rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < WIDTH + 2; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      check("abort_no_done", ndone, 0);
      issue(AND_OP, 8'hF0, 8'h3C);
      @(negedge clk);
      check("and_result", bus.output_1, 8'h30);
      check("and_done", bus.done, 1);

      // Randomized traffic, with occasional asynchronous reset pulses
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(posedge clk); #1;
         if ($urandom % 150 == 0) begin
            rst_n = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
         end else begin
            bus.start   = ($urandom % 3) != 0;
            bus.op      = ($urandom % 4 == 0) ? MUL : 3'($urandom);
            bus.input_1 = pick_operand();
            bus.input_2 = pick_operand();
         end
      end
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (WIDTH + 3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
